// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multiply/divide sequencer and its datapath.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MDIDLE = 2'd0,
        MDPREP = 2'd1,
        MDRUN  = 2'd2,
        MDFIX  = 2'd3
    } md_state_e;

    localparam logic [6:0] WORD_STEPS  = 7'd32;
    localparam logic [6:0] DWORD_STEPS = 7'd64;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Datapath for muldiv: operand conditioning, one shift-add / restoring-divide
// step per cycle, and final sign correction and word-mode extension.
module muldiv_dp
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        prep,
    input  logic        step,
    input  logic        fix,
    input  logic        op_div,
    input  logic        op_dword,
    input  logic        op_signed,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    output logic        div_zero,
    output logic [6:0]  steps,
    output logic [63:0] hi_res,
    output logic [63:0] lo_res
);

    logic [63:0]  a_raw_q, a_raw_d, b_raw_q, b_raw_d, opd_q, opd_d;
    logic [127:0] acc_q, acc_d;
    logic         div_q, div_d, dword_q, dword_d, sgn_q, sgn_d;
    logic         neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic [63:0]  a_ext_s, b_ext_s, a_mag_s, b_mag_s;
    logic         a_neg_s, b_neg_s;
    logic [64:0]  mul_sum_s, div_shift_s;
    logic         div_ge_s;
    logic [63:0]  div_rem_s;
    logic [127:0] prod_s, prod_fix_s;
    logic [63:0]  quo_fix_s, rem_fix_s, hi_raw_s, lo_raw_s;

    assign div_zero = div_q & (b_ext_s == 64'd0);
    assign steps    = dword_q ? DWORD_STEPS : WORD_STEPS;

    // Operand conditioning, per-step arithmetic and final result shaping
    always_comb begin
        hi_raw_s = 64'd0;
        lo_raw_s = 64'd0;
        a_ext_s  = dword_q ? a_raw_q
                 : (sgn_q ? sext32(a_raw_q[31:0]) : {32'd0, a_raw_q[31:0]});
        b_ext_s  = dword_q ? b_raw_q
                 : (sgn_q ? sext32(b_raw_q[31:0]) : {32'd0, b_raw_q[31:0]});
        a_neg_s  = sgn_q & a_ext_s[63];
        b_neg_s  = sgn_q & b_ext_s[63];
        a_mag_s  = a_neg_s ? (64'd0 - a_ext_s) : a_ext_s;
        b_mag_s  = b_neg_s ? (64'd0 - b_ext_s) : b_ext_s;

        mul_sum_s   = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, opd_q} : 65'd0);
        div_shift_s = {acc_q[127:64], acc_q[63]};
        div_ge_s    = (div_shift_s >= {1'b0, opd_q});
        div_rem_s   = div_ge_s ? (div_shift_s[63:0] - opd_q) : div_shift_s[63:0];

        // A word product sits 32 bits up after only 32 right shifts
        prod_s     = dword_q ? acc_q : {64'd0, acc_q[95:32]};
        prod_fix_s = neg_q ? (128'd0 - prod_s) : prod_s;
        quo_fix_s  = neg_q ? (64'd0 - acc_q[63:0]) : acc_q[63:0];
        rem_fix_s  = rneg_q ? (64'd0 - acc_q[127:64]) : acc_q[127:64];

        if (!div_q) begin
            hi_raw_s = dword_q ? prod_fix_s[127:64] : {32'd0, prod_fix_s[63:32]};
            lo_raw_s = prod_fix_s[63:0];
        end else if (dz_q) begin
            hi_raw_s = acc_q[127:64];
            lo_raw_s = acc_q[63:0];
        end else begin
            hi_raw_s = rem_fix_s;
            lo_raw_s = quo_fix_s;
        end
        hi_res = dword_q ? hi_raw_s : sext32(hi_raw_s[31:0]);
        lo_res = dword_q ? lo_raw_s : sext32(lo_raw_s[31:0]);
    end

    // Next-state for operand latches and the shared product/quotient accumulator
    always_comb begin
        a_raw_d = a_raw_q;
        b_raw_d = b_raw_q;
        div_d   = div_q;
        dword_d = dword_q;
        sgn_d   = sgn_q;
        opd_d   = opd_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        if (load) begin
            a_raw_d = op_a;
            b_raw_d = op_b;
            div_d   = op_div;
            dword_d = op_dword;
            sgn_d   = op_signed;
        end else if (prep) begin
            opd_d  = div_q ? b_mag_s : a_mag_s;
            neg_d  = a_neg_s ^ b_neg_s;
            rneg_d = a_neg_s;
            dz_d   = div_zero;
            if (!div_q) begin
                acc_d = {64'd0, b_mag_s};
            end else if (div_zero) begin
                acc_d = {a_ext_s, 64'hFFFF_FFFF_FFFF_FFFF};
            end else if (dword_q) begin
                acc_d = {64'd0, a_mag_s};
            end else begin
                acc_d = {64'd0, a_mag_s[31:0], 32'd0};
            end
        end else if (step) begin
            if (!div_q) begin
                acc_d = {mul_sum_s, acc_q[63:1]};
            end else begin
                acc_d = {div_rem_s, acc_q[62:0], div_ge_s};
            end
        end else if (fix) begin
            acc_d = 128'd0;
        end else begin
            acc_d = acc_q;
        end
    end

    // Datapath register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            a_raw_q <= 64'd0;
            b_raw_q <= 64'd0;
            div_q   <= 1'b0;
            dword_q <= 1'b0;
            sgn_q   <= 1'b0;
            opd_q   <= 64'd0;
            acc_q   <= 128'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            a_raw_q <= a_raw_d;
            b_raw_q <= b_raw_d;
            div_q   <= div_d;
            dword_q <= dword_d;
            sgn_q   <= sgn_d;
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: rtl/muldiv.sv
// Multi-cycle multiply/divide sequencer: owns HI/LO, sequences the datapath,
// and arbitrates kill, reset and MTHI/MTLO writes.
module muldiv
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mdstart,
    input  logic        mddiv,
    input  logic        mddword,
    input  logic        mdsigned,
    input  logic [63:0] mda,
    input  logic [63:0] mdb,
    input  logic        hiwe,
    input  logic        lowe,
    input  logic [63:0] hilowd,
    input  logic        mdkill,
    output logic        mdbusy,
    output logic        mddone,
    output logic [63:0] hi,
    output logic [63:0] lo
);

    md_state_e   state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] hi_q, hi_d, lo_q, lo_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        accept_s, prep_s, step_s, fix_s, div_zero_s;
    logic [6:0]  steps_s;
    logic [63:0] hi_res_s, lo_res_s;

    muldiv_dp u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s),
        .prep      (prep_s),
        .step      (step_s),
        .fix       (fix_s),
        .op_div    (mddiv),
        .op_dword  (mddword),
        .op_signed (mdsigned),
        .op_a      (mda),
        .op_b      (mdb),
        .div_zero  (div_zero_s),
        .steps     (steps_s),
        .hi_res    (hi_res_s),
        .lo_res    (lo_res_s)
    );

    // Sequencer next-state, HI/LO write arbitration and datapath enables
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        accept_s = 1'b0;
        prep_s   = 1'b0;
        step_s   = 1'b0;
        fix_s    = 1'b0;
        case (state_q)
            MDIDLE: begin
                if (hiwe) hi_d = hilowd;
                else      hi_d = hi_q;
                if (lowe) lo_d = hilowd;
                else      lo_d = lo_q;
                if (mdstart && !mdkill) begin
                    accept_s = 1'b1;
                    state_d  = MDPREP;
                end else begin
                    state_d  = MDIDLE;
                end
            end
            MDPREP: begin
                prep_s = 1'b1;
                if (mdkill) begin
                    state_d = MDIDLE;
                    cnt_d   = 7'd0;
                end else if (div_zero_s) begin
                    state_d = MDFIX;
                    cnt_d   = 7'd0;
                end else begin
                    state_d = MDRUN;
                    cnt_d   = steps_s;
                end
            end
            MDRUN: begin
                if (mdkill) begin
                    state_d = MDIDLE;
                    cnt_d   = 7'd0;
                end else begin
                    step_s = 1'b1;
                    cnt_d  = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) state_d = MDFIX;
                    else               state_d = MDRUN;
                end
            end
            MDFIX: begin
                // A kill arriving with completion wins: HI/LO stay untouched
                if (mdkill) begin
                    state_d = MDIDLE;
                end else begin
                    fix_s   = 1'b1;
                    hi_d    = hi_res_s;
                    lo_d    = lo_res_s;
                    done_d  = 1'b1;
                    state_d = MDIDLE;
                end
            end
            default: begin
                state_d = MDIDLE;
                cnt_d   = 7'd0;
            end
        endcase
        busy_d = (state_d != MDIDLE);
    end

    // Sequencer and architectural register state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDIDLE;
            cnt_q   <= 7'd0;
            hi_q    <= 64'd0;
            lo_q    <= 64'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mdbusy = busy_q;
    assign mddone = done_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed and randomised checks of muldiv with a queue of expected HI/LO results.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdstart = 1'b0, mddiv = 1'b0, mddword = 1'b0, mdsigned = 1'b0;
    logic [63:0] mda = 64'd0, mdb = 64'd0;
    logic        hiwe = 1'b0, lowe = 1'b0;
    logic [63:0] hilowd = 64'd0;
    logic        mdkill = 1'b0;
    logic        mdbusy, mddone;
    logic [63:0] hi, lo;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [63:0] MT_DATA = 64'hABCD_0000_0000_ABCD;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    muldiv dut (
        .clk(clk), .rst(rst), .mdstart(mdstart), .mddiv(mddiv), .mddword(mddword),
        .mdsigned(mdsigned), .mda(mda), .mdb(mdb), .hiwe(hiwe), .lowe(lowe),
        .hilowd(hilowd), .mdkill(mdkill), .mdbusy(mdbusy), .mddone(mddone),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Issue one op in the current cycle, then wait for mddone and score it.
    task automatic do_op(input string tag, input logic dv, input logic dw, input logic sg,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] hi_e, input logic [63:0] lo_e,
                         input int poke, input logic mt);
        exp_t        e;
        int          cyc;
        int          lat_e;
        logic        busy_ok;
        logic [63:0] b_eff;
        b_eff = dw ? b : {32'd0, b[31:0]};
        lat_e = (dv && b_eff == 64'd0) ? 3 : (dw ? 67 : 35);
        sb.push_back('{hi: hi_e, lo: lo_e, lat: lat_e});
        mddiv = dv; mddword = dw; mdsigned = sg; mda = a; mdb = b;
        mdstart = 1'b1; hiwe = mt; hilowd = MT_DATA;
        tick();
        mdstart = 1'b0; hiwe = 1'b0;
        if (mt) chk({tag, "_mt_hi"}, hi, MT_DATA);
        cyc = 1;
        busy_ok = 1'b1;
        while (mddone !== 1'b1 && cyc < 100) begin
            if (mdbusy !== 1'b1) busy_ok = 1'b0;
            mdstart = (cyc == poke);
            tick();
            mdstart = 1'b0;
            cyc++;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, 64'(cyc), 64'(e.lat));
        chk({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
        chk({tag, "_idle"}, {63'd0, mdbusy}, 64'd0);
        chk({tag, "_hi"}, hi, e.hi);
        chk({tag, "_lo"}, lo, e.lo);
    endtask

    initial begin
        logic [63:0]  ra, rb;
        logic [127:0] rp;
        longint       sa, sbv;
        logic [63:0]  sp;
        logic         seen;

        tick(); tick();
        chk("rst_hi", hi, 64'd0);
        chk("rst_lo", lo, 64'd0);
        chk("rst_busy", {63'd0, mdbusy}, 64'd0);
        chk("rst_done", {63'd0, mddone}, 64'd0);
        rst = 1'b0;
        tick();

        do_op("mult_m3x7", 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
              ONES, 64'hFFFF_FFFF_FFFF_FFEB, 5, 1'b0);
        do_op("dmultu_ones", 1'b0, 1'b1, 1'b0, ONES, ONES,
              64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0, 1'b0);
        do_op("div_m7d2", 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              ONES, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b0);
        do_op("ddivu_100d7", 1'b1, 1'b1, 1'b0, 64'd100, 64'd7, 64'd2, 64'd14, 0, 1'b0);
        do_op("divu_dz", 1'b1, 1'b0, 1'b0, 64'd5, 64'hFFFF_FFFF_0000_0000,
              64'd5, ONES, 0, 1'b0);
        do_op("divu_dz_sx", 1'b1, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'd0,
              64'hFFFF_FFFF_8000_0000, ONES, 0, 1'b0);
        do_op("div_ovf", 1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'd0, 64'hFFFF_FFFF_8000_0000, 0, 1'b0);
        do_op("ddiv_ovf", 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, ONES,
              64'd0, 64'h8000_0000_0000_0000, 0, 1'b0);
        do_op("multu_mt", 1'b0, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0, 1'b1);
        do_op("ddiv_7dm2", 1'b1, 1'b1, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
              64'd1, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b0);
        do_op("dmult_m5x6", 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd6,
              ONES, 64'hFFFF_FFFF_FFFF_FFE2, 0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rp = {64'd0, ra} * {64'd0, rb};
            do_op("rnd_dmultu", 1'b0, 1'b1, 1'b0, ra, rb, rp[127:64], rp[63:0], 0, 1'b0);
            rb = {32'd0, $urandom} | 64'd1;
            do_op("rnd_ddivu", 1'b1, 1'b1, 1'b0, ra, rb, ra % rb, ra / rb, 0, 1'b0);
            sa  = longint'($signed(ra[31:0]));
            sbv = longint'($signed(rb[31:0]));
            sp  = 64'(sa * sbv);
            do_op("rnd_mult", 1'b0, 1'b0, 1'b1, ra, rb,
                  {{32{sp[63]}}, sp[63:32]}, {{32{sp[31]}}, sp[31:0]}, 0, 1'b0);
        end

        hiwe = 1'b1; hilowd = 64'h1234;
        tick();
        hiwe = 1'b0;
        chk("mthi", hi, 64'h1234);
        lowe = 1'b1; hilowd = 64'h5678;
        tick();
        lowe = 1'b0;
        chk("mtlo", lo, 64'h5678);

        mddiv = 1'b0; mddword = 1'b1; mdsigned = 1'b1; mda = 64'd9; mdb = 64'd9;
        mdstart = 1'b1;
        tick();
        mdstart = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        mdkill = 1'b1;
        tick();
        mdkill = 1'b0;
        chk("kill_busy", {63'd0, mdbusy}, 64'd0);
        chk("kill_hi", hi, 64'h1234);
        chk("kill_done", {63'd0, mddone}, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (mddone === 1'b1 || mdbusy === 1'b1) seen = 1'b1;
            tick();
        end
        chk("kill_quiet", {63'd0, seen}, 64'd0);
        chk("kill_lo", lo, 64'h5678);

        mddiv = 1'b1; mddword = 1'b1; mdsigned = 1'b0; mda = 64'd1000; mdb = 64'd3;
        mdstart = 1'b1;
        tick();
        mdstart = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rrun_hi", hi, 64'd0);
        chk("rrun_lo", lo, 64'd0);
        chk("rrun_busy", {63'd0, mdbusy}, 64'd0);
        chk("rrun_done", {63'd0, mddone}, 64'd0);
        do_op("after_rst", 1'b1, 1'b1, 1'b0, 64'd1000, 64'd3, 64'd1, 64'd333, 0, 1'b0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv.md
# muldiv

Multi-cycle multiply/divide sequencer and HI/LO owner for the 64-bit integer pipeline. It accepts MULT/MULTU/DIV/DIVU/DMULT/DMULTU/DDIV/DDIVU issued from execute (decoded with ALU op MUL or DIV plus the signed and dword flags), runs them one bit per cycle, and writes HI/LO. It raises `mdbusy` so the pipeline interlocks MFHI/MFLO/MTHI/MTLO and the next mul/div behind it.

## Interface
No parameters; operand width is fixed at 64.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high.
- `mdstart` in 1: one-cycle issue pulse; sampled only in IDLE.
- `mddiv` in 1: 0 = multiply, 1 = divide.
- `mddword` in 1: 1 = 64-bit (D*) op, 0 = 32-bit op.
- `mdsigned` in 1: signed operation.
- `mda` in 64: rs operand (multiplicand / dividend).
- `mdb` in 64: rt operand (multiplier / divisor).
- `hiwe`, `lowe` in 1: MTHI/MTLO write strobes.
- `hilowd` in 64: MTHI/MTLO data.
- `mdkill` in 1: abort from exception flush.
- `mdbusy` out 1: operation in progress.
- `mddone` out 1: one-cycle pulse in the cycle HI/LO first show a new result.
- `hi`, `lo` out 64: architectural HI/LO registers.

## Operation
- States: IDLE, PREP, RUN, FIX. 7-bit iteration counter.
- IDLE → PREP on `mdstart`. PREP latches operands. In word mode, `mda[31:0]`/`mdb[31:0]` are sign- or zero-extended per `mdsigned`, and N = 32; otherwise N = 64. PREP takes magnitudes when signed and records the result signs.
- PREP → RUN with counter = N. Exception: divide with divisor zero goes PREP → FIX directly.
- RUN: one step per cycle; counter decrements; RUN → FIX when counter reaches 1.
  - Multiply: shift-add, 2N-bit product.
  - Divide: restoring, N-bit quotient and remainder.
- FIX: sign-correct the result, write HI/LO, then → IDLE.
  - Multiply: HI = upper N bits, LO = lower N bits of the product; product negated if operand signs differ.
  - Divide: LO = quotient, negated if signs differ. HI = remainder, carrying the sign of the dividend.
  - Word mode: HI and LO are each sign-extended from bit 31.
- Divide by zero: LO = all ones (word mode: 64'hFFFF_FFFF_FFFF_FFFF); HI = dividend, sign-extended from bit 31 in word mode.
- Signed overflow (min / −1): LO = min (word mode: 64'hFFFF_FFFF_8000_0000), HI = 0.
- `hiwe`/`lowe` write `hilowd` to HI/LO only in IDLE. They are dropped while busy; this is a pipeline interlock violation and the bench asserts on it.
- `mdstart` together with `hiwe` in IDLE: the MT write lands now, and the op result overwrites it in FIX.
- `mdstart` while busy is ignored.
- `mdkill` in PREP/RUN/FIX: → IDLE next cycle, HI/LO unchanged, no `mddone`. `mdkill` takes priority over FIX completion in the same cycle. `mdkill` with `mdstart` in IDLE: the start is dropped.
- `rst`: state IDLE, `hi` = `lo` = 0, `mdbusy` = 0, `mddone` = 0, counter 0.

## Timing
- `mdstart` in cycle 0. PREP occupies cycle 1, RUN occupies cycles 2..N+1, FIX occupies cycle N+2.
- New HI/LO are visible in cycle N+3, with `mddone` = 1 in that same cycle.
- `mdbusy` = 1 in cycles 1..N+2 (34 for word ops, 66 for dword ops).
- Divide by zero: busy in cycles 1..2; result and `mddone` in cycle 3.
- `mdbusy` is registered: asserts the cycle after `mdstart`. Execute must also stall on `mdstart` in the issue cycle.
- A back-to-back `mdstart` is accepted in cycle N+3 or later.
- MT writes take effect the cycle after the strobe.

## Structure
- Add to `cpuconst.vh`: state encodings (MDIDLE, MDPREP, MDRUN, MDFIX).
- Top module `muldiv`: state machine, counter, HI/LO registers, kill/MT arbitration.
- One sub-module, `muldiv_dp`: operand conditioning, shift-add/restore step, and final negation/sign-extension. It is driven by step/prep/fix enables from `muldiv`.

## Test plan
- MULT word signed, a=−3, b=7 → cycle 35: `mddone`=1, `lo`=64'hFFFF_FFFF_FFFF_FFEB, `hi`=64'hFFFF_FFFF_FFFF_FFFF; `mdbusy` high in cycles 1..34 exactly.
- DMULTU a=b=64'hFFFF_FFFF_FFFF_FFFF → cycle 67: `hi`=64'hFFFF_FFFF_FFFF_FFFE, `lo`=1.
- DIV signed a=−7, b=2 → `lo`=−3, `hi`=−1. DDIVU a=100, b=7 → `lo`=14, `hi`=2.
- DIVU word a=5, b=0 → cycle 3: `lo`=64'hFFFF_FFFF_FFFF_FFFF, `hi`=5. DIV a=32'h8000_0000, b=−1 → `lo`=64'hFFFF_FFFF_8000_0000, `hi`=0.
- MTHI 64'h1234 in IDLE → `hi`=64'h1234 next cycle. Start DMULT, assert `mdkill` in cycle 20 → IDLE in cycle 21, `hi` still 64'h1234, no `mddone`.
- `rst` asserted during RUN → next cycle `hi`=`lo`=0, `mdbusy`=0. A fresh `mdstart` afterwards completes normally.
